// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps the {s1,s0} select of an external 4:1 mux through all
// four channels. After each select change it waits SETTLE cycles, then samples
// y once. The four samples are presented as one frame with a valid/ready
// handshake.
// Optional build macro MUX_SCAN_CONT_EN: continuous mode. After each handshake
// the next scan starts immediately, without another start pulse.
`timescale 1ns/1ps

module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       s1,
  output logic       s0,
  input  logic       y,
  output logic [3:0] frame,
  output logic       valid,
  input  logic       ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  // Last settle count before sampling. It is unused when SETTLE is 0, because
  // that build never enters ST_SETTLE.
  localparam logic [3:0] SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
  // State entered after every select change.
  localparam state_t FIRST = (SETTLE > 0) ? ST_SETTLE : ST_SAMPLE;

  state_t     state, state_nxt;
  logic [1:0] sel, sel_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [2:0] work, work_nxt;   // channels 0..2; channel 3 goes straight to frame
  logic [3:0] frame_q, frame_nxt;

  assign s1    = sel[1];
  assign s0    = sel[0];
  assign frame = frame_q;
  assign valid = (state == ST_DONE);
  assign busy  = (state != ST_IDLE);

  // Next-state and datapath update for the scan sequence
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    cnt_nxt   = cnt;
    work_nxt  = work;
    frame_nxt = frame_q;
    case (state)
      ST_IDLE: begin
        if (start) begin
          sel_nxt   = 2'd0;
          cnt_nxt   = 4'd0;
          state_nxt = FIRST;
        end
      end
      ST_SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          cnt_nxt   = 4'd0;
          state_nxt = ST_SAMPLE;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      ST_SAMPLE: begin
        if (sel == 2'd3) begin
          // Last channel: publish the frame. sel returns to 0 explicitly
          // here, not by counter overflow.
          frame_nxt = {y, work};
          sel_nxt   = 2'd0;
          state_nxt = ST_DONE;
        end else begin
          case (sel)
            2'd0:    work_nxt[0] = y;
            2'd1:    work_nxt[1] = y;
            default: work_nxt[2] = y;
          endcase
          sel_nxt   = sel + 2'd1;
          cnt_nxt   = 4'd0;
          state_nxt = FIRST;
        end
      end
      ST_DONE: begin
        if (ready) begin
`ifdef MUX_SCAN_CONT_EN
          sel_nxt   = 2'd0;
          cnt_nxt   = 4'd0;
          state_nxt = FIRST;
`else
          state_nxt = ST_IDLE;
`endif
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything, including the frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      sel     <= 2'd0;
      cnt     <= 4'd0;
      work    <= 3'd0;
      frame_q <= 4'd0;
    end else begin
      state   <= state_nxt;
      sel     <= sel_nxt;
      cnt     <= cnt_nxt;
      work    <= work_nxt;
      frame_q <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Testbench for mux_scan_ctrl. It has two instances: SETTLE=1 and SETTLE=0.
// A bench-side mux drives y from the DUT select. A timeline model predicts
// the outputs on every cycle, and directed literals pin key cycles.
`timescale 1ns/1ps

module tb_mux_scan_ctrl;

  localparam int SET_A = 1;
  localparam int SET_B = 0;

  logic       clk = 1'b0;
  logic       rst    [2];
  logic       start  [2];
  logic       ready  [2];
  logic       s1     [2];
  logic       s0     [2];
  logic       y      [2];
  logic       valid  [2];
  logic       busy   [2];
  logic [3:0] frame  [2];
  logic [3:0] mux_in [2];   // {i3,i2,i1,i0} per instance

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: time since the scan began, plus the done flag and the frame
  bit         m_act  [2];
  bit         m_done [2];
  int         m_t    [2];
  logic [3:0] m_work [2];
  logic [3:0] m_frame[2];

  always #5 clk = ~clk;

  assign y[0] = mux_in[0][{s1[0], s0[0]}];
  assign y[1] = mux_in[1][{s1[1], s0[1]}];

  mux_scan_ctrl #(.SETTLE(SET_A)) dut_a (
    .clk(clk), .rst(rst[0]), .start(start[0]), .s1(s1[0]), .s0(s0[0]),
    .y(y[0]), .frame(frame[0]), .valid(valid[0]), .ready(ready[0]), .busy(busy[0])
  );

  mux_scan_ctrl #(.SETTLE(SET_B)) dut_b (
    .clk(clk), .rst(rst[1]), .start(start[1]), .s1(s1[1]), .s0(s0[1]),
    .y(y[1]), .frame(frame[1]), .valid(valid[1]), .ready(ready[1]), .busy(busy[1])
  );

  function automatic int period(input int d);
    return (d == 0) ? SET_A + 1 : SET_B + 1;
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d at %0t: got=%0h expected=%0h", name, d, $time, got, exp);
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int p;
      int k;
      p = period(d);
      if (rst[d]) begin
        m_act[d] = 1'b0; m_done[d] = 1'b0; m_t[d] = 0;
        m_work[d] = 4'd0; m_frame[d] = 4'd0;
      end else if (m_done[d]) begin
        if (ready[d]) begin
          m_done[d] = 1'b0;
`ifdef MUX_SCAN_CONT_EN
          m_act[d] = 1'b1; m_t[d] = 0;
`endif
        end
      end else if (m_act[d]) begin
        if (m_t[d] % p == p - 1) begin
          k = m_t[d] / p;
          m_work[d][k] = mux_in[d][k];
          if (k == 3) begin
            m_frame[d] = m_work[d];
            m_done[d]  = 1'b1;
            m_act[d]   = 1'b0;
          end
        end
        m_t[d]++;
      end else if (start[d]) begin
        m_act[d] = 1'b1; m_t[d] = 0;
      end
    end
  endtask

  // Advance the model at each active edge
  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare all outputs against the model on every falling edge
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        int es;
        es = m_act[d] ? m_t[d] / period(d) : 0;
        chk("sel",   d, {s1[d], s0[d]}, es);
        chk("valid", d, valid[d], m_done[d]);
        chk("busy",  d, busy[d], m_act[d] | m_done[d]);
        chk("frame", d, frame[d], m_frame[d]);
      end
    end
  end

  initial begin
    rst[0] = 1'b1; rst[1] = 1'b1;
    start[0] = 1'b0; start[1] = 1'b0;
    ready[0] = 1'b0; ready[1] = 1'b0;
    mux_in[0] = 4'b1101;
    mux_in[1] = 4'b0110;
    repeat (3) @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    chk_en = 1'b1;
    chk("rst_valid", 0, valid[0], 0);
    chk("rst_busy",  0, busy[0], 0);
    chk("rst_frame", 0, frame[0], 4'b0000);
    chk("rst_sel",   1, {s1[1], s0[1]}, 0);

`ifndef MUX_SCAN_CONT_EN
    // Scan with backpressure; a second start in cycle 3 must be ignored
    start[0] = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      start[0] = (n == 3);
      ready[0] = (n >= 14);
      if (n <= 8) chk("sel_seq", 0, {s1[0], s0[0]}, (n - 1) / 2);
      if (n >= 9 && n <= 14) begin
        chk("valid_hold", 0, valid[0], 1);
        chk("frame_hold", 0, frame[0], 4'b1101);
      end
      if (n == 15) begin
        chk("valid_after_hs", 0, valid[0], 0);
        chk("busy_after_hs",  0, busy[0], 0);
        chk("frame_kept",     0, frame[0], 4'b1101);
      end
    end
    repeat (6) @(negedge clk);
    chk("no_second_frame", 0, valid[0], 0);

    // Reset in the middle of a scan, then a fresh scan
    mux_in[0] = 4'b1010;
    start[0] = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      start[0] = 1'b0;
      rst[0] = (n == 4);
      if (n == 5) begin
        chk("midrst_sel",   0, {s1[0], s0[0]}, 0);
        chk("midrst_valid", 0, valid[0], 0);
        chk("midrst_busy",  0, busy[0], 0);
        chk("midrst_frame", 0, frame[0], 4'b0000);
      end
    end
    start[0] = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      start[0] = 1'b0;
      if (n == 9) begin
        chk("rescan_valid", 0, valid[0], 1);
        chk("rescan_frame", 0, frame[0], 4'b1010);
      end
      if (n == 10) chk("rescan_hs", 0, valid[0], 0);
    end

    // SETTLE=0: the select advances every cycle
    ready[1] = 1'b1;
    start[1] = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      start[1] = 1'b0;
      if (n <= 4) chk("s0_sel_seq", 1, {s1[1], s0[1]}, n - 1);
      if (n == 5) begin
        chk("s0_valid", 1, valid[1], 1);
        chk("s0_frame", 1, frame[1], 4'b0110);
      end
      if (n == 6) chk("s0_done", 1, busy[1], 0);
    end
`else
    // Continuous mode: one start, ready tied high, a new frame every 9 cycles
    ready[0] = 1'b1;
    start[0] = 1'b1;
    for (int n = 1; n <= 28; n++) begin
      @(negedge clk);
      start[0] = 1'b0;
      if (n == 9) begin
        chk("cont_v1", 0, valid[0], 1);
        chk("cont_f1", 0, frame[0], 4'b1101);
        mux_in[0] = 4'b0101;
      end
      if (n == 10) begin
        chk("cont_gap",  0, valid[0], 0);
        chk("cont_busy", 0, busy[0], 1);
      end
      if (n == 18) begin
        chk("cont_v2", 0, valid[0], 1);
        chk("cont_f2", 0, frame[0], 4'b0101);
        mux_in[0] = 4'b1000;
      end
      if (n == 27) begin
        chk("cont_v3", 0, valid[0], 1);
        chk("cont_f3", 0, frame[0], 4'b1000);
      end
    end
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
